// File: rtl/miriscv_data_initiator.sv
// miriscv data-memory initiator: accepts one load/store command at a time,
// issues a single-cycle request on the data bus, waits for rvalid and returns
// the extracted/extended load data, or an error for illegal, misaligned or
// timed-out accesses.
module miriscv_data_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        arstn_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [1:0]  cmd_size_i,
    input  logic        cmd_unsigned_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1; one bit minimum keeps it legal
    // when the timeout is disabled or trivially short.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    state_t        state_reg;
    logic          we_reg;
    logic [1:0]    size_reg;
    logic          unsigned_reg;
    logic [1:0]    off_reg;
    logic [CW-1:0] cnt_reg;

    logic          cmd_legal;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   load_shift;
    logic [31:0]   load_next;
    logic          timeout_hit;

    assign cmd_ready_o = (state_reg == IDLE);

    // Size 3 is illegal; halves need addr[0]=0, words need addr[1:0]=0.
    assign cmd_legal = (cmd_size_i == 2'd0) ||
                       ((cmd_size_i == 2'd1) && !cmd_addr_i[0]) ||
                       ((cmd_size_i == 2'd2) && (cmd_addr_i[1:0] == 2'b00));

    // Per-lane byte enable: a lane is active if the access covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be_next[gi] = (cmd_size_i == 2'd2) ||
                                 ((cmd_size_i == 2'd1) && (LANE[1] == cmd_addr_i[1])) ||
                                 ((cmd_size_i == 2'd0) && (LANE == cmd_addr_i[1:0]));
        end
    endgenerate

    // Replicate store data across the word so every lane carries it.
    always_comb begin
        wdata_next = cmd_wdata_i;
        case (cmd_size_i)
            2'd0:    wdata_next = {4{cmd_wdata_i[7:0]}};
            2'd1:    wdata_next = {2{cmd_wdata_i[15:0]}};
            default: wdata_next = cmd_wdata_i;
        endcase
    end

    assign load_shift = data_rdata_i >> {off_reg, 3'b000};

    // Narrow the shifted read word to the access size and extend it.
    always_comb begin
        load_next = load_shift;
        case (size_reg)
            2'd0:    load_next = unsigned_reg ? {24'h0, load_shift[7:0]}
                                              : {{24{load_shift[7]}}, load_shift[7:0]};
            2'd1:    load_next = unsigned_reg ? {16'h0, load_shift[15:0]}
                                              : {{16{load_shift[15]}}, load_shift[15:0]};
            default: load_next = load_shift;
        endcase
    end

    // Last permitted WAIT cycle without rvalid; timeout beats a coincident rvalid.
    assign timeout_hit = TO_EN && (cnt_reg == TO_LAST);

    // Command FSM with registered bus and response outputs.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= 2'd0;
            unsigned_reg <= 1'b0;
            off_reg      <= 2'd0;
            cnt_reg      <= '0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'h0;
            data_addr_o  <= 32'h0;
            data_wdata_o <= 32'h0;
            rsp_valid_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
            rsp_rdata_o  <= 32'h0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'h0;
            data_req_o  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_legal) begin
                            we_reg       <= cmd_we_i;
                            size_reg     <= cmd_size_i;
                            unsigned_reg <= cmd_unsigned_i;
                            off_reg      <= cmd_addr_i[1:0];
                            cnt_reg      <= '0;
                            data_req_o   <= 1'b1;
                            data_we_o    <= cmd_we_i;
                            data_be_o    <= be_next;
                            data_addr_o  <= cmd_addr_i;
                            data_wdata_o <= cmd_we_i ? wdata_next : 32'h0;
                            state_reg    <= REQ;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (timeout_hit) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        state_reg   <= IDLE;
                    end else if (data_rvalid_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= we_reg ? 32'h0 : load_next;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_data_initiator.sv
// Bench for miriscv_data_initiator: scoreboarded requests and responses with
// cycle-exact latency, a simple memory responder, timeout and reset cases.
module tb_miriscv_data_initiator;

    logic        clk;
    logic        arstn_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [1:0]  cmd_size_i;
    logic        cmd_unsigned_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    miriscv_data_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i          (clk),
        .arstn_i        (arstn_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_size_i     (cmd_size_i),
        .cmd_unsigned_i (cmd_unsigned_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_wdata_i    (cmd_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .data_req_o     (data_req_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    rsp_t        rsp_q[$];
    req_t        req_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        auto_resp = 1'b1;
    logic [31:0] resp_word = 32'h0;
    int          inject_req = 0;
    int          acc;
    int          acc_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Memory responder: rvalid one cycle after the request cycle, plus
    // bench-requested stray rvalid pulses.
    initial begin : responder
        logic        pend;
        logic [31:0] pend_word;
        int          inject_ack;
        pend = 1'b0;
        pend_word = 32'h0;
        inject_ack = 0;
        data_rvalid_i = 1'b0;
        data_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            data_rvalid_i = pend;
            data_rdata_i  = pend ? pend_word : 32'hBAADF00D;
            if (inject_req != inject_ack) begin
                data_rvalid_i = 1'b1;
                inject_ack = inject_req;
            end
            pend = 1'b0;
            if (data_req_o && auto_resp) begin
                pend = 1'b1;
                pend_word = resp_word;
            end
        end
    end

    // Output monitor, sampling on the falling edge.
    initial begin : monitor
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (data_req_o) begin
                check("req_double", {31'h0, prev_req}, 32'h0);
                if (req_q.size() == 0) begin
                    check("spurious_req", {31'h0, data_req_o}, 32'h0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check("req_cycle", cyc, r.cyc);
                    check("req_we", {31'h0, data_we_o}, {31'h0, r.we});
                    check("req_be", {28'h0, data_be_o}, {28'h0, r.be});
                    check("req_addr", data_addr_o, r.addr);
                    check("req_wdata", data_wdata_o, r.wdata);
                end
            end
            prev_req = data_req_o;
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    check("spurious_rsp", {31'h0, rsp_valid_o}, 32'h0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_cycle", cyc, e.cyc);
                    check("rsp_err", {31'h0, rsp_err_o}, {31'h0, e.err});
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                end
            end else if (rsp_err_o || (rsp_rdata_o != 32'h0)) begin
                check("rsp_idle", (rsp_err_o ? 32'h1 : 32'h0) | rsp_rdata_o, 32'h0);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mem_word,
                         input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic push_rsp, input logic exp_err, input logic [31:0] exp_rdata,
                         input int lat, output int acc_cyc);
        int n;
        @(negedge clk);
        cmd_valid_i    = 1'b1;
        cmd_we_i       = we;
        cmd_size_i     = size;
        cmd_unsigned_i = uns;
        cmd_addr_i     = addr;
        cmd_wdata_i    = wdata;
        resp_word      = mem_word;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) check("cmd_ready_wait", {31'h0, cmd_ready_o}, 32'h1);
        acc_cyc = cyc;
        if (exp_req) req_q.push_back('{cyc: acc_cyc + 1, we: we, be: exp_be, addr: addr, wdata: exp_wd});
        if (push_rsp) rsp_q.push_back('{cyc: acc_cyc + lat, err: exp_err, rdata: exp_rdata});
        $display("cmd @%0d we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h", acc_cyc, we, size, uns, addr, wdata);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : stim
        int n;
        cmd_valid_i = 1'b0;
        cmd_we_i = 1'b0;
        cmd_size_i = 2'd0;
        cmd_unsigned_i = 1'b0;
        cmd_addr_i = 32'h0;
        cmd_wdata_i = 32'h0;
        arstn_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, data_req_o}, 32'h0);
        check("rst_we", {31'h0, data_we_o}, 32'h0);
        check("rst_be", {28'h0, data_be_o}, 32'h0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_ready", {31'h0, cmd_ready_o}, 32'h1);
        arstn_i = 1'b1;
        repeat (2) @(negedge clk);

        // Loads: word, signed/unsigned byte, signed half (back-to-back).
        issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 3, acc);
        issue(1'b0, 2'd0, 1'b0, 32'h05, 32'h0, 32'h12348056, 1'b1, 4'b0010, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80, 3, acc);
        issue(1'b0, 2'd0, 1'b1, 32'h05, 32'h0, 32'h12348056, 1'b1, 4'b0010, 32'h0, 1'b1, 1'b0, 32'h00000080, 3, acc);
        issue(1'b0, 2'd1, 1'b0, 32'h06, 32'h0, 32'h12348056, 1'b1, 4'b1100, 32'h0, 1'b1, 1'b0, 32'h00001234, 3, acc);
        issue(1'b0, 2'd1, 1'b0, 32'h04, 32'h0, 32'h12348056, 1'b1, 4'b0011, 32'h0, 1'b1, 1'b0, 32'hFFFF8056, 3, acc);

        // Stores: half and byte; then a load accepted in the store's response cycle.
        issue(1'b1, 2'd1, 1'b0, 32'h06, 32'h0000ABCD, 32'hFFFFFFFF, 1'b1, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 32'h0, 3, acc);
        acc_prev = acc;
        issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'h0BADCAFE, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h0BADCAFE, 3, acc);
        check("b2b_accept", acc, acc_prev + 3);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h123456A5, 32'h0, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 3, acc);

        // Illegal / misaligned: immediate error, no request.
        issue(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1, acc);
        issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1, acc);
        issue(1'b1, 2'd1, 1'b0, 32'h01, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1, acc);
        repeat (3) @(negedge clk);

        // Timeout with TIMEOUT_CYCLES=4, then stray rvalids.
        auto_resp = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h0, 6, acc);
        wait_cycle(acc + 6);
        inject_req++;
        @(negedge clk);
        inject_req++;
        repeat (4) @(negedge clk);

        // Asynchronous reset during WAIT.
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h55AA55AA, 32'h0, 1'b1, 4'b1111, 32'h55AA55AA, 1'b0, 1'b0, 32'h0, 3, acc);
        wait_cycle(acc + 3);
        #2;
        arstn_i = 1'b0;
        #1;
        check("arst_req", {31'h0, data_req_o}, 32'h0);
        check("arst_we", {31'h0, data_we_o}, 32'h0);
        check("arst_be", {28'h0, data_be_o}, 32'h0);
        check("arst_addr", data_addr_o, 32'h0);
        check("arst_wdata", data_wdata_o, 32'h0);
        check("arst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        @(negedge clk);
        arstn_i = 1'b1;
        inject_req++;
        repeat (3) @(negedge clk);
        auto_resp = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 3, acc);

        n = 0;
        while ((rsp_q.size() != 0 || req_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("rsp_left", rsp_q.size(), 32'h0);
        check("req_left", req_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
